// File: rtl/reservoir_pkg.sv
// Shared constants for the reservoir flow controller: parameter defaults,
// debounce counter width and the saturating fault-counter limits.
package reservoir_pkg;

    localparam int NUM_SENSORS_DEFAULT   = 3;
    localparam int STABLE_CYCLES_DEFAULT = 1;

    // Holds STABLE_CYCLES up to 15
    localparam int CNT_W = 4;

    localparam int              FAULT_CNT_W   = 8;
    localparam logic [7:0]      FAULT_CNT_MAX = 8'd255;

endpackage

// File: rtl/level_debounce.sv
// Validates the thermometer-coded sensor sample, converts it to a level and
// debounces it; strobes accept when a new level has been seen often enough.
module level_debounce
    import reservoir_pkg::*;
#(
    parameter  int NUM_SENSORS   = NUM_SENSORS_DEFAULT,
    parameter  int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    localparam int LW            = $clog2(NUM_SENSORS + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SENSORS-1:0] s,
    input  logic [LW-1:0]          level,
    output logic                   accept,
    output logic [LW-1:0]          accept_level,
    output logic                   invalid
);

    localparam logic [CNT_W-1:0] STABLE  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                valid;
    logic [LW-1:0]       raw;
    logic [LW-1:0]       cand;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;

    // A sensor may only be wet if every sensor below it is wet too
    always_comb begin
        valid = 1'b1;
        for (int i = 1; i < NUM_SENSORS; i++) begin
            if (s[i] && !s[i-1]) begin
                valid = 1'b0;
            end
        end
    end

    always_comb begin
        raw = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (s[i]) begin
                raw = raw + LW'(1);
            end
        end
    end

    // Re-presenting the accepted level cancels any pending candidate
    always_comb begin
        cnt_next = cnt;
        if (!valid || raw == level) begin
            cnt_next = '0;
        end else if (raw != cand) begin
            cnt_next = CNT_W'(1);
        end else if (cnt != CNT_MAX) begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    assign accept       = valid && (raw != level) && (cnt_next == STABLE);
    assign accept_level = raw;
    assign invalid      = !valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand <= '0;
            cnt  <= '0;
        end else begin
            cnt <= cnt_next;
            if (valid) begin
                cand <= raw;
            end
        end
    end

endmodule

// File: rtl/reservoir_flow_ctrl.sv
// Reservoir flow controller: debounced water level drives the nominal flow
// valves and a supplemental valve with hysteresis on the direction of change.
module reservoir_flow_ctrl
    import reservoir_pkg::*;
#(
    parameter  int NUM_SENSORS   = NUM_SENSORS_DEFAULT,
    parameter  int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    localparam int LW            = $clog2(NUM_SENSORS + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SENSORS-1:0] s,
    output logic [NUM_SENSORS-1:0] fr,
    output logic                   dfr,
    output logic [LW-1:0]          level,
    output logic                   fault,
    output logic [FAULT_CNT_W-1:0] fault_cnt
);

    logic                   accept;
    logic [LW-1:0]          accept_level;
    logic                   invalid;
    logic [NUM_SENSORS-1:0] fr_next;
    logic                   dfr_next;

    level_debounce #(
        .NUM_SENSORS   (NUM_SENSORS),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_debounce (
        .clk          (clk),
        .reset        (reset),
        .s            (s),
        .level        (level),
        .accept       (accept),
        .accept_level (accept_level),
        .invalid      (invalid)
    );

    // Lower water opens more valves: the bottom (N - level) valves are open
    always_comb begin
        fr_next = '0;
        for (int k = 0; k < NUM_SENSORS; k++) begin
            fr_next[k] = (k < (NUM_SENSORS - int'(accept_level)));
        end
    end

    always_comb begin
        dfr_next = dfr;
        if (accept_level == '0) begin
            dfr_next = 1'b1;
        end else if (accept_level == LW'(NUM_SENSORS)) begin
            dfr_next = 1'b0;
        end else if (accept_level < level) begin
            dfr_next = 1'b1;
        end else if (accept_level > level) begin
            dfr_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level     <= '0;
            fr        <= '1;
            dfr       <= 1'b1;
            fault     <= 1'b0;
            fault_cnt <= '0;
        end else begin
            fault <= invalid;
            if (invalid && fault_cnt != FAULT_CNT_MAX) begin
                fault_cnt <= fault_cnt + FAULT_CNT_W'(1);
            end
            if (accept) begin
                level <= accept_level;
                fr    <= fr_next;
                dfr   <= dfr_next;
            end
        end
    end

endmodule

// File: tb/tb_reservoir_flow_ctrl.sv
// Scoreboard bench: three controller instances (N=3/S=1, N=3/S=3, N=5/S=2)
// checked each cycle against a sample-history reference model.
module tb_reservoir_flow_ctrl;

    typedef struct {
        int lvl;
        int fr;
        int dfr;
        int fault;
        int fcnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [2:0] s3;
    logic [4:0] s5;

    logic [2:0] fr_a, fr_b;
    logic [4:0] fr_c;
    logic       dfr_a, dfr_b, dfr_c;
    logic [1:0] level_a, level_b;
    logic [2:0] level_c;
    logic       fault_a, fault_b, fault_c;
    logic [7:0] fcnt_a, fcnt_b, fcnt_c;

    int checks = 0;
    int errors = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    int nsens[3] = '{3, 3, 5};
    int stab[3]  = '{1, 3, 2};
    int m_lvl[3];
    int m_dfr[3];
    int m_fault[3];
    int m_fcnt[3];
    int m_hlen[3];
    int m_hist[3][16];

    always #5 clk = ~clk;

    reservoir_flow_ctrl #(.NUM_SENSORS(3), .STABLE_CYCLES(1)) dut_a (
        .clk(clk), .reset(reset), .s(s3), .fr(fr_a), .dfr(dfr_a),
        .level(level_a), .fault(fault_a), .fault_cnt(fcnt_a)
    );

    reservoir_flow_ctrl #(.NUM_SENSORS(3), .STABLE_CYCLES(3)) dut_b (
        .clk(clk), .reset(reset), .s(s3), .fr(fr_b), .dfr(dfr_b),
        .level(level_b), .fault(fault_b), .fault_cnt(fcnt_b)
    );

    reservoir_flow_ctrl #(.NUM_SENSORS(5), .STABLE_CYCLES(2)) dut_c (
        .clk(clk), .reset(reset), .s(s5), .fr(fr_c), .dfr(dfr_c),
        .level(level_c), .fault(fault_c), .fault_cnt(fcnt_c)
    );

    function automatic exp_t model_expect(int d);
        exp_t e;
        e.lvl   = m_lvl[d];
        e.fr    = (1 << (nsens[d] - m_lvl[d])) - 1;
        e.dfr   = m_dfr[d];
        e.fault = m_fault[d];
        e.fcnt  = m_fcnt[d];
        return e;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 3; d++) begin
            m_lvl[d]   = 0;
            m_dfr[d]   = 1;
            m_fault[d] = 0;
            m_fcnt[d]  = 0;
            m_hlen[d]  = 0;
        end
    endfunction

    // A level is accepted once the last STABLE samples were all the same
    // valid level and that level differs from the one currently accepted
    function automatic exp_t model_step(int d, int sv);
        int pc = 0;
        bit ok;
        bit run;
        for (int i = 0; i < 8; i++) begin
            if (sv[i]) pc++;
        end
        ok = (sv == (1 << pc) - 1);
        for (int i = 15; i > 0; i--) m_hist[d][i] = m_hist[d][i-1];
        m_hist[d][0] = ok ? pc : -1;
        if (m_hlen[d] < 16) m_hlen[d]++;
        m_fault[d] = ok ? 0 : 1;
        if (!ok && m_fcnt[d] < 255) m_fcnt[d]++;
        if (ok && pc != m_lvl[d] && m_hlen[d] >= stab[d]) begin
            run = 1'b1;
            for (int i = 0; i < stab[d]; i++) begin
                if (m_hist[d][i] != pc) run = 1'b0;
            end
            if (run) begin
                if (pc == 0)                m_dfr[d] = 1;
                else if (pc == nsens[d])    m_dfr[d] = 0;
                else if (pc < m_lvl[d])     m_dfr[d] = 1;
                else                        m_dfr[d] = 0;
                m_lvl[d] = pc;
            end
        end
        return model_expect(d);
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_output(input int d, input exp_t e, input string tag);
        logic [31:0] a_lvl, a_fr, a_dfr, a_fault, a_fcnt;
        case (d)
            0: begin
                a_lvl = 32'(level_a); a_fr = 32'(fr_a); a_dfr = 32'(dfr_a);
                a_fault = 32'(fault_a); a_fcnt = 32'(fcnt_a);
            end
            1: begin
                a_lvl = 32'(level_b); a_fr = 32'(fr_b); a_dfr = 32'(dfr_b);
                a_fault = 32'(fault_b); a_fcnt = 32'(fcnt_b);
            end
            default: begin
                a_lvl = 32'(level_c); a_fr = 32'(fr_c); a_dfr = 32'(dfr_c);
                a_fault = 32'(fault_c); a_fcnt = 32'(fcnt_c);
            end
        endcase
        compare({tag, "_level"},     a_lvl,   e.lvl);
        compare({tag, "_fr"},        a_fr,    e.fr);
        compare({tag, "_dfr"},       a_dfr,   e.dfr);
        compare({tag, "_fault"},     a_fault, e.fault);
        compare({tag, "_fault_cnt"}, a_fcnt,  e.fcnt);
    endtask

    // Called at a falling edge; the response is due on the next rising edge
    task automatic apply_stimulus(input logic [2:0] v3, input logic [4:0] v5);
        s3 = v3;
        s5 = v5;
        q_a.push_back(model_step(0, int'(v3)));
        q_b.push_back(model_step(1, int'(v3)));
        q_c.push_back(model_step(2, int'(v5)));
        @(negedge clk);
    endtask

    task automatic async_reset_check(input string tag);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_output(0, model_expect(0), {tag, "_a"});
        check_output(1, model_expect(1), {tag, "_b"});
        check_output(2, model_expect(2), {tag, "_c"});
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) begin e = q_a.pop_front(); check_output(0, e, "a"); end
            if (q_b.size() > 0) begin e = q_b.pop_front(); check_output(1, e, "b"); end
            if (q_c.size() > 0) begin e = q_c.pop_front(); check_output(2, e, "c"); end
        end
    end

    initial begin : stimulus
        logic [2:0] r3;
        logic [4:0] r5;
        reset = 1'b1;
        s3 = '0;
        s5 = '0;
        model_reset();
        #2;
        check_output(0, model_expect(0), "rst_a");
        check_output(1, model_expect(1), "rst_b");
        check_output(2, model_expect(2), "rst_c");
        @(negedge clk);
        reset = 1'b0;

        apply_stimulus(3'b111, 5'b11111);
        apply_stimulus(3'b000, 5'b11111);
        apply_stimulus(3'b001, 5'b00011);
        apply_stimulus(3'b011, 5'b00011);
        apply_stimulus(3'b001, 5'b00011);
        apply_stimulus(3'b000, 5'b00011);

        apply_stimulus(3'b001, 5'b00001);
        apply_stimulus(3'b001, 5'b00001);
        apply_stimulus(3'b000, 5'b00001);
        repeat (3) apply_stimulus(3'b001, 5'b00000);
        apply_stimulus(3'b101, 5'b01001);
        apply_stimulus(3'b001, 5'b00000);

        apply_stimulus(3'b011, 5'b00111);
        apply_stimulus(3'b011, 5'b00111);
        async_reset_check("midrst");
        repeat (3) apply_stimulus(3'b011, 5'b00111);

        r3 = '0;
        r5 = '0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) >= 5) begin
                if ($urandom_range(0, 7) == 0) r3 = 3'($urandom);
                else r3 = 3'((1 << $urandom_range(0, 3)) - 1);
                if ($urandom_range(0, 7) == 0) r5 = 5'($urandom);
                else r5 = 5'((1 << $urandom_range(0, 5)) - 1);
            end
            apply_stimulus(r3, r5);
            if (n == 200) async_reset_check("rndrst");
        end

        repeat (300) apply_stimulus(3'b101, 5'b10101);
        repeat (3) apply_stimulus(3'b000, 5'b00000);

        compare("queue_drain", 32'(q_a.size() + q_b.size() + q_c.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
